mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Moore FSM sequencing a multi-cycle MIPS datapath over shared PC/IR/MDR/A/B/ALUOut registers and one unified memory port.
//  Decodes opcode/funct and steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
//  Emits every datapath strobe and mux select, and stalls on memory wait states via mem_ready.
//  Supported instructions: R-type (add, sub, or, slt, nor, sll, jr), lw, sw, beq, addi, ori, j, jal.
// PARAMETERS
//  OPW     6  opcode/funct field width
//  STATEW  4  state register width (exported on dbg_state)
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-high reset
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory handshake: access completes on this edge when 1
//  pc_write     out  1  unconditional PC load
//  pc_write_cond out 1  PC load qualified by zero (beq)
//  i_or_d       out  1  memory address select: 0=PC, 1=ALUOut
//  mem_read     out  1  memory read strobe
//  mem_write    out  1  memory write strobe
//  ir_write     out  1  IR load
//  reg_dst      out  2  write register select: 0=rt, 1=rd, 2=$31
//  mem_to_reg   out  2  write data select: 0=ALUOut, 1=MDR, 2=PC
//  reg_write    out  1  register file write enable
//  alu_src_a    out  1  ALU A input: 0=PC, 1=A
//  alu_src_b    out  2  ALU B input: 0=B, 1=const 4, 2=signext, 3=signext<<2
//  alu_op       out  3  0=add, 1=sub, 2=funct, 3=or, 4=sll (AluControl encoding)
//  pc_source    out  2  PC source: 0=ALU, 1=ALUOut, 2=jump target, 3=A (jr)
//  instr_done   out  1  one-cycle pulse in the final state of each instruction
//  halted       out  1  high in HALT
//  dbg_state    out  4  current state
// BEHAVIOUR
//  - reset asserted: state=RST immediately; all outputs 0. RST->FETCH on the first edge after release.
//  - Outputs are pure Moore decodes of state; any field not listed for a state is 0.
//  - FETCH: mem_read, ir_write, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0, pc_write.
//    Strobes ir_write/pc_write are gated by mem_ready; FETCH holds while mem_ready=0.
//  - DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut). Next state by opcode:
//    0 with funct 8 -> JR; 0 otherwise -> EXEC_R; 35/43 -> MEM_ADDR; 4 -> BRANCH;
//    8 -> EXEC_I (alu_op=0); 13 -> EXEC_I (alu_op=3); 2 -> JUMP; 3 -> JAL; other -> HALT.
//  - EXEC_R: alu_src_a=1, alu_src_b=0; alu_op=4 if funct==0 (sll), else 2. Next: R_WB.
//  - R_WB: reg_dst=1, mem_to_reg=0, reg_write, instr_done. Next: FETCH.
//  - MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Next: MEM_RD (lw) or MEM_WR (sw).
//  - MEM_RD: i_or_d=1, mem_read; holds while !mem_ready, then MEM_WB.
//  - MEM_WB: reg_dst=0, mem_to_reg=1, reg_write, instr_done.
//  - MEM_WR: i_or_d=1, mem_write, instr_done only on the mem_ready cycle; holds while !mem_ready.
//  - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1, pc_write_cond, instr_done.
//  - EXEC_I: alu_src_a=1, alu_src_b=2; alu_op latched from opcode in DECODE. Next: I_WB.
//  - I_WB: reg_dst=0, mem_to_reg=0, reg_write, instr_done.
//  - JUMP: pc_source=2, pc_write, instr_done.
//  - JAL: pc_source=2, pc_write, reg_dst=2, mem_to_reg=2, reg_write, instr_done.
//    PC already holds PC+4 here, so the link value is PC+4.
//  - JR: pc_source=3, pc_write, instr_done; reg_write=0.
//  - HALT: halted=1, all strobes 0; exit only via reset.
//  - Latency with mem_ready=1: R/addi/ori/sw 4 cycles, lw 5, beq/j/jal/jr 3.
//    Each FETCH/MEM wait cycle adds 1.
//  - Reset mid-instruction aborts it; a partially waited write is never strobed after reset.
// STRUCTURE
//  - Shared package mips_mc_pkg holds:
//    state localparams (RST, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, BRANCH,
//    EXEC_I, I_WB, JUMP, JAL, JR, HALT); opcode/funct constants; alu_op, pc_source, reg_dst and
//    mem_to_reg encodings.
//  - One sub-module, mc_output_decode: combinational state(+funct, latched alu_op, mem_ready) -> control word.
//  - The top holds the state register, next-state logic and the latched I-type alu_op.
// TESTING
//  - Reset during MEM_WR with mem_ready=0 -> mem_write falls asynchronously; state=RST, then FETCH.
//  - add (op 0, funct 32), mem_ready=1 -> states FETCH, DECODE, EXEC_R, R_WB; reg_dst=1, alu_op=2.
//    instr_done pulses on cycle 4.
//  - lw with mem_ready low 2 cycles in MEM_RD -> 7 total cycles; reg_write only in MEM_WB, mem_to_reg=1.
//  - beq -> BRANCH with alu_op=1, pc_write_cond=1, pc_source=1; 3 cycles.
//  - jal (op 3) -> JAL with reg_dst=2, mem_to_reg=2, pc_source=2, reg_write and pc_write both 1.
//    jr (funct 8) -> pc_source=3, reg_write=0.
//  - Opcode 63 -> HALT; halted=1 held for 20 cycles with all strobes 0 until reset.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared states, opcode/funct constants, control encodings and control word for the multicycle MIPS controller
package mips_mc_pkg;

    typedef enum logic [3:0] {
        RST, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R,
        R_WB, BRANCH, EXEC_I, I_WB, JUMP, JAL, JR, HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_JR    = 6'd8;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SLL   = 3'd4;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MDR = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       halted;
    } ctrl_t;

    // Dispatch out of DECODE; anything unrecognised parks the machine in HALT.
    function automatic state_t decode_next(logic [5:0] op, logic [5:0] fn);
        return (op == OP_RTYPE)              ? ((fn == FN_JR) ? JR : EXEC_R) :
               (op == OP_LW || op == OP_SW)  ? MEM_ADDR :
               (op == OP_BEQ)                ? BRANCH :
               (op == OP_ADDI || op == OP_ORI) ? EXEC_I :
               (op == OP_J)                  ? JUMP :
               (op == OP_JAL)                ? JAL : HALT;
    endfunction

endpackage

// File: rtl/mips_multicycle_control_decode.sv
// mc_output_decode: Moore decode of controller state into the datapath control word
//   state_i     current FSM state
//   funct_i     IR[5:0], selects sll vs funct-driven ALU op in EXEC_R
//   alu_lat_i   I-type ALU op captured in DECODE
//   mem_ready_i memory handshake, gates FETCH strobes and sw completion
//   ctrl_o      full control word
module mc_output_decode
    import mips_mc_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] funct_i,
    input  logic [2:0] alu_lat_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
                ctrl_o.alu_src_b = SRCB_FOUR;
            end
            DECODE: ctrl_o.alu_src_b = SRCB_IMMSH;
            EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = (funct_i == FN_SLL) ? ALU_SLL : ALU_FUNCT;
            end
            R_WB: begin
                ctrl_o.reg_dst    = RD_RD;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            MEM_RD: begin
                ctrl_o.i_or_d   = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            MEM_WB: begin
                ctrl_o.mem_to_reg = WD_MDR;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            MEM_WR: begin
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_source     = PC_ALUOUT;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.instr_done    = 1'b1;
            end
            EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = alu_lat_i;
            end
            I_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            JUMP: begin
                ctrl_o.pc_source  = PC_JUMP;
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            JAL: begin
                ctrl_o.pc_source  = PC_JUMP;
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.reg_dst    = RD_RA;
                ctrl_o.mem_to_reg = WD_PC;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            JR: begin
                ctrl_o.pc_source  = PC_REG;
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            HALT: ctrl_o.halted = 1'b1;
            default: ctrl_o = '0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore FSM sequencing a multicycle MIPS datapath with memory wait states
//   clk, reset        rising-edge clock, async active-high reset
//   opcode, funct     IR fields (opcode valid from DECODE onward)
//   zero              ALU zero flag (consumed by the datapath via pc_write_cond)
//   mem_ready         unified memory handshake
//   pc_write .. halted datapath strobes and mux selects
//   dbg_state         current state
module mips_multicycle_control
    import mips_mc_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int STATEW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPW-1:0]    opcode,
    input  logic [OPW-1:0]    funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic              i_or_d,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic [1:0]        reg_dst,
    output logic [1:0]        mem_to_reg,
    output logic              reg_write,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [2:0]        alu_op,
    output logic [1:0]        pc_source,
    output logic              instr_done,
    output logic              halted,
    output logic [STATEW-1:0] dbg_state
);
    state_t     state_q, state_d;
    logic [2:0] alu_i_q, alu_i_d;
    ctrl_t      ctrl;
    logic       zero_unused;

    // zero only qualifies pc_write_cond inside the datapath.
    assign zero_unused = zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RST;
            alu_i_q <= ALU_ADD;
        end else begin
            state_q <= state_d;
            alu_i_q <= alu_i_d;
        end
    end

    // The opcode may be stale by EXEC_I, so its ALU op is captured while IR is known good.
    assign alu_i_d = (state_q == DECODE) ? ((opcode == OP_ORI) ? ALU_OR : ALU_ADD) : alu_i_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RST:      state_d = FETCH;
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE:   state_d = decode_next(opcode, funct);
            MEM_ADDR: state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   state_d = mem_ready ? MEM_WB : MEM_RD;
            MEM_WR:   state_d = mem_ready ? FETCH : MEM_WR;
            EXEC_R:   state_d = R_WB;
            EXEC_I:   state_d = I_WB;
            HALT:     state_d = HALT;
            default:  state_d = FETCH;
        endcase
    end

    mc_output_decode u_dec (
        .state_i     (state_q),
        .funct_i     (funct),
        .alu_lat_i   (alu_i_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign instr_done    = ctrl.instr_done;
    assign halted        = ctrl.halted;
    assign dbg_state     = STATEW'(state_q);
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: randomized instruction streams checked against a per-instruction phase model
module tb_mips_multicycle_control;
    import mips_mc_pkg::*;

    logic       clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic       reg_write, alu_src_a, instr_done, halted;
    logic [2:0] alu_op;
    logic [3:0] dbg_state;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .halted(halted),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] observed();
        return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, halted};
    endfunction

    // Control word each phase of an instruction must present.
    function automatic logic [20:0] exp_ctrl(state_t s, int op, int fn, bit r);
        logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, rw = 0, asa = 0, done = 0, hlt = 0;
        logic [1:0] rd = 0, m2r = 0, asb = 0, pcs = 0;
        logic [2:0] aop = 0;
        case (s)
            FETCH:    begin mr = 1; irw = r; pw = r; asb = 1; end
            DECODE:   asb = 3;
            EXEC_R:   begin asa = 1; aop = (fn == 0) ? 3'd4 : 3'd2; end
            R_WB:     begin rd = 1; rw = 1; done = 1; end
            MEM_ADDR: begin asa = 1; asb = 2; end
            MEM_RD:   begin iod = 1; mr = 1; end
            MEM_WB:   begin m2r = 1; rw = 1; done = 1; end
            MEM_WR:   begin iod = 1; mw = 1; done = r; end
            BRANCH:   begin asa = 1; aop = 1; pcs = 1; pwc = 1; done = 1; end
            EXEC_I:   begin asa = 1; asb = 2; aop = (op == 13) ? 3'd3 : 3'd0; end
            I_WB:     begin rw = 1; done = 1; end
            JUMP:     begin pcs = 2; pw = 1; done = 1; end
            JAL:      begin pcs = 2; pw = 1; rd = 2; m2r = 2; rw = 1; done = 1; end
            JR:       begin pcs = 3; pw = 1; done = 1; end
            HALT:     hlt = 1;
            default:  ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, done, hlt};
    endfunction

    task automatic step(input state_t s, input bit r, input int op, input int fn, output bit done);
        bit junk;
        @(negedge clk);
        junk = (s == FETCH || s == EXEC_I || s == I_WB || s == HALT);
        mem_ready = r;
        opcode = junk ? 6'($urandom) : 6'(op);
        funct = (s == FETCH) ? 6'($urandom) : 6'(fn);
        zero = 1'($urandom);
        #1;
        check($sformatf("%s.state", s.name()), 32'(dbg_state), 32'(s));
        check($sformatf("%s.ctrl op%0d", s.name(), op), 32'(observed()), 32'(exp_ctrl(s, op, fn, r)));
        done = instr_done;
    endtask

    // keep>0 truncates the instruction after that many cycles (used to abort it by reset).
    task automatic run_instr(input int op, input int fn, input int fw, input int mw, input int keep);
        state_t sq[$];
        int     lat, done_at = 0, dones = 0, n;
        bit     d, r, halt = 0;
        for (int i = 0; i <= fw; i++) sq.push_back(FETCH);
        sq.push_back(DECODE);
        lat = 3;
        if (op == 0 && fn == 8) sq.push_back(JR);
        else if (op == 0) begin sq.push_back(EXEC_R); sq.push_back(R_WB); lat = 4; end
        else if (op == 35) begin
            sq.push_back(MEM_ADDR);
            for (int i = 0; i <= mw; i++) sq.push_back(MEM_RD);
            sq.push_back(MEM_WB); lat = 5 + mw;
        end else if (op == 43) begin
            sq.push_back(MEM_ADDR);
            for (int i = 0; i <= mw; i++) sq.push_back(MEM_WR);
            lat = 4 + mw;
        end else if (op == 4) sq.push_back(BRANCH);
        else if (op == 8 || op == 13) begin sq.push_back(EXEC_I); sq.push_back(I_WB); lat = 4; end
        else if (op == 2) sq.push_back(JUMP);
        else if (op == 3) sq.push_back(JAL);
        else begin halt = 1; for (int i = 0; i < 20; i++) sq.push_back(HALT); end
        lat += fw;
        n = (keep > 0) ? keep : sq.size();
        for (int i = 0; i < n; i++) begin
            // A waitable phase sees ready=0 exactly when the model repeats it next cycle.
            if (sq[i] == FETCH || sq[i] == MEM_RD || sq[i] == MEM_WR)
                r = !(i + 1 < sq.size() && sq[i + 1] == sq[i]);
            else
                r = 1'($urandom);
            step(sq[i], r, op, fn, d);
            if (d) begin dones++; if (done_at == 0) done_at = i + 1; end
        end
        if (keep == 0) begin
            check($sformatf("latency op%0d fn%0d", op, fn), 32'(done_at), halt ? 32'd0 : 32'(lat));
            check($sformatf("done count op%0d", op), 32'(dones), halt ? 32'd0 : 32'd1);
        end
    endtask

    // Reset asserted mid-cycle must clear everything immediately; release leaves RST for one edge.
    task automatic do_reset();
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("reset.state", 32'(dbg_state), 32'(RST));
        check("reset.ctrl", 32'(observed()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset.hold.state", 32'(dbg_state), 32'(RST));
        check("reset.hold.ctrl", 32'(observed()), 32'd0);
    endtask

    int ops[14] = '{0, 0, 0, 0, 0, 0, 0, 35, 43, 4, 8, 13, 2, 3};
    int fns[14] = '{32, 34, 37, 42, 39, 0, 8, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        int k;
        do_reset();
        run_instr(0, 32, 0, 0, 0);
        run_instr(35, 5, 0, 2, 0);
        run_instr(4, 9, 0, 0, 0);
        run_instr(3, 17, 0, 0, 0);
        run_instr(0, 8, 0, 0, 0);
        run_instr(0, 0, 1, 0, 0);
        run_instr(13, 3, 0, 0, 0);
        run_instr(8, 3, 2, 0, 0);
        run_instr(43, 1, 0, 3, 0);
        run_instr(2, 60, 0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 13);
            run_instr(ops[k], (ops[k] == 0) ? fns[k] : 32'($urandom_range(0, 63)),
                      32'($urandom_range(0, 2)), 32'($urandom_range(0, 3)), 0);
        end
        run_instr(43, 2, 0, 5, 6);
        do_reset();
        run_instr(0, 34, 0, 0, 0);
        run_instr(63, 0, 0, 0, 0);
        do_reset();
        run_instr(0, 42, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
